// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared processor defines for the memory responder.
//               Holds the default data/address width, the two IO port
//               addresses and the responder FSM state encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam int           c_width       = 8;
    localparam logic [7:0]   c_io_in_adr   = 8'hFE;
    localparam logic [7:0]   c_io_out_adr  = 8'hFF;

    // Responder FSM encoding
    localparam int               c_st_w    = 1;
    localparam logic [c_st_w-1:0] c_st_load = 1'b0;
    localparam logic [c_st_w-1:0] c_st_run  = 1'b1;

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_ram
// Description : Single-port byte RAM covering addresses 0 .. LIMIT-1.
//               Combinational read, synchronous write. The single address
//               port is muxed between the boot loader and the processor.
// Ports       : clk        - clock
//               load_sel   - 1: loader owns the port, 0: processor owns it
//               ld_we/ld_adr/ld_data    - loader write request
//               cpu_we/cpu_adr/cpu_data - processor write request
//               rdata      - RAM[address], 0 for addresses outside the RAM
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ram #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = 8'hFE
) (
    input  logic             clk,
    input  logic             load_sel,
    input  logic             ld_we,
    input  logic [WIDTH-1:0] ld_adr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_data,
    output logic [WIDTH-1:0] rdata
);

    localparam int c_depth = int'(LIMIT);

    logic [WIDTH-1:0] r_mem [0:c_depth-1];

    logic             w_we;
    logic [WIDTH-1:0] w_adr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_in_range;

    assign w_we       = load_sel ? ld_we   : cpu_we;
    assign w_adr      = load_sel ? ld_adr  : cpu_adr;
    assign w_wdata    = load_sel ? ld_data : cpu_data;
    // IO addresses sit above the RAM and must never alias into it
    assign w_in_range = (w_adr < LIMIT);

    // Contents are deliberately not reset: a reload after reset keeps them.
    always_ff @(posedge clk) begin
        if (w_we && w_in_range) begin
            r_mem[w_adr] <= w_wdata;
        end
    end

    assign rdata = w_in_range ? r_mem[w_adr] : '0;

endmodule : mem_ram
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Processor memory responder with boot loader. After reset the
//               responder is in LOAD, holding the CPU in reset and streaming
//               loader bytes into RAM. On the last byte (or RAM overflow) it
//               moves to RUN and serves processor reads/writes to RAM plus a
//               registered input port and an output port register.
// Ports       : clk, reset (sync, active-high)
//               memread, memwrite, adr, writedata, memdata - processor bus
//               load_valid, load_data, load_last, load_ready - boot loader
//               cpu_reset  - holds processor in reset during LOAD
//               load_err   - sticky: image filled RAM without load_last
//               in_port    - external input (sampled every cycle)
//               out_port, out_valid - output register and update pulse
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int               WIDTH      = c_width,
    parameter logic [WIDTH-1:0] IO_IN_ADR  = c_io_in_adr,
    parameter logic [WIDTH-1:0] IO_OUT_ADR = c_io_out_adr
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             load_ready,
    output logic             cpu_reset,
    output logic             load_err,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] c_last_ram = IO_IN_ADR - {{(WIDTH-1){1'b0}}, 1'b1};

    logic [c_st_w-1:0] r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_ld_adr, w_ld_adr_nxt;
    logic              r_load_err, w_load_err_nxt;
    logic [WIDTH-1:0]  r_out_port;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_in_q;

    logic              w_accept;
    logic              w_run;
    logic              w_wr_ram;
    logic              w_wr_out;
    logic [WIDTH-1:0]  w_ram_rdata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_load;
            r_ld_adr   <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ld_adr   <= w_ld_adr_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_adr_nxt   = r_ld_adr;
        w_load_err_nxt = r_load_err;
        w_accept       = 1'b0;
        load_ready     = 1'b0;
        cpu_reset      = 1'b0;
        case (r_state)
            c_st_load: begin
                load_ready = 1'b1;
                cpu_reset  = 1'b1;
                w_accept   = load_valid;
                if (load_valid) begin
                    if (load_last) begin
                        w_state_nxt = c_st_run;
                    end else if (r_ld_adr == c_last_ram) begin
                        // RAM full without a last marker: stop here rather
                        // than letting the load address run into IO space
                        w_state_nxt    = c_st_run;
                        w_load_err_nxt = 1'b1;
                    end else begin
                        w_ld_adr_nxt = r_ld_adr + 1'b1;
                    end
                end
            end
            default: begin
                // RUN: loader inputs ignored, left only by reset
            end
        endcase
    end

    assign load_err = r_load_err;

    // ---------------- Processor side ----------------
    assign w_run    = (r_state == c_st_run);
    assign w_wr_out = w_run && memwrite && (adr == IO_OUT_ADR);
    assign w_wr_ram = w_run && memwrite && (adr < IO_IN_ADR);

    mem_ram #(
        .WIDTH (WIDTH),
        .LIMIT (IO_IN_ADR)
    ) u_mem_ram (
        .clk      (clk),
        .load_sel (~w_run),
        .ld_we    (w_accept),
        .ld_adr   (r_ld_adr),
        .ld_data  (load_data),
        .cpu_we   (w_wr_ram),
        .cpu_adr  (adr),
        .cpu_data (writedata),
        .rdata    (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_port  <= '0;
            r_out_valid <= 1'b0;
            r_in_q      <= '0;
        end else begin
            r_in_q      <= in_port;
            r_out_valid <= w_wr_out;
            if (w_wr_out) begin
                r_out_port <= writedata;
            end
        end
    end

    assign out_port  = r_out_port;
    assign out_valid = r_out_valid;

    // Read data reflects current (pre-write) state, so a combined read/write
    // returns the old value.
    always_comb begin
        memdata = '0;
        if (w_run && memread) begin
            if (adr == IO_IN_ADR) begin
                memdata = r_in_q;
            end else if (adr == IO_OUT_ADR) begin
                memdata = r_out_port;
            end else begin
                memdata = w_ram_rdata;
            end
        end
    end

endmodule : mem_responder
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, default 8: data and address width; address space 2^WIDTH bytes.
REQ-002 Parameter IO_IN_ADR, default 8'hFE: read-only input port address.
REQ-003 Parameter IO_OUT_ADR, default 8'hFF: output port address.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 memread  input  1  processor read request.
REQ-007 memwrite  input  1  processor write request.
REQ-008 adr  input  WIDTH  processor byte address.
REQ-009 writedata  input  WIDTH  processor write data.
REQ-010 memdata  output  WIDTH  read data returned to processor.
REQ-011 load_valid  input  1  boot loader byte available.
REQ-012 load_data  input  WIDTH  boot loader byte.
REQ-013 load_last  input  1  qualifies final boot byte (valid with load_valid).
REQ-014 load_ready  output  1  responder accepts boot byte this cycle.
REQ-015 cpu_reset  output  1  holds processor in reset while loading.
REQ-016 load_err  output  1  sticky: image overflowed RAM without load_last.
REQ-017 in_port  input  WIDTH  external input port.
REQ-018 out_port  output  WIDTH  external output register.
REQ-019 out_valid  output  1  one-cycle pulse on each out_port update.

Function
REQ-020 RAM SHALL cover addresses 0 through IO_IN_ADR-1 (254 bytes at default); IO addresses SHALL NOT map to RAM.
REQ-021 FSM SHALL have two states: LOAD (after reset) and RUN.
REQ-022 In LOAD: load_ready=1, cpu_reset=1; on load_valid, load_data SHALL be written to RAM[ld_adr] and ld_adr SHALL increment.
REQ-023 LOAD->RUN when a byte is accepted with load_last=1; cpu_reset SHALL read 0 from the following cycle.
REQ-024 LOAD->RUN with load_err=1 when the byte at IO_IN_ADR-1 is accepted without load_last; ld_adr SHALL never wrap into IO space.
REQ-025 In RUN: load_ready=0, cpu_reset=0, all load inputs ignored; RUN is left only by reset.
REQ-026 In LOAD, memread/memwrite SHALL be ignored and memdata SHALL be 0.
REQ-027 RUN read: memdata SHALL be combinational from adr in the same cycle: RAM[adr], in_q at IO_IN_ADR, out_port at IO_OUT_ADR; 0 when memread=0.
REQ-028 in_q SHALL register in_port every cycle (one-cycle sampling latency).
REQ-029 RUN write to RAM address: RAM[adr] SHALL update at the clock edge; read of same adr in next cycle returns new value.
REQ-030 RUN write to IO_OUT_ADR: out_port SHALL load writedata at the edge; out_valid SHALL be 1 for exactly the next cycle.
REQ-031 Writes to IO_IN_ADR SHALL have no effect.
REQ-032 memread and memwrite together: write SHALL occur; memdata SHALL show the pre-write value.
REQ-033 Back-to-back writes to IO_OUT_ADR SHALL pulse out_valid on each consecutive cycle.

Reset
REQ-034 Reset SHALL set state=LOAD, ld_adr=0, cpu_reset=1, load_ready=1, load_err=0, out_port=0, out_valid=0, in_q=0.
REQ-035 Reset asserted mid-load or mid-run SHALL abort immediately; RAM contents SHALL NOT be cleared.

Structure
REQ-036 WIDTH default, IO_IN_ADR, IO_OUT_ADR and FSM state encodings SHALL live in the shared processor defines package.
REQ-037 RAM array (combinational read, synchronous write, single port with write-address mux between loader and processor) SHALL be sub-module mem_ram.

Verification
REQ-038 Load 4 bytes 11,22,33,44 (last on 44) -> RAM[0..3] holds them, cpu_reset falls one cycle after 44 accepted, load_err=0.
REQ-039 Stream 254 bytes without load_last -> load_err=1, RUN entered, RAM[0xFD]=last byte, load_ready=0 thereafter.
REQ-040 RUN: memwrite adr=0x10 data=0xA5, then memread adr=0x10 -> memdata=0xA5 next cycle.
REQ-041 RUN: memwrite adr=0xFF data=0x3C -> out_port=0x3C, out_valid high one cycle; memread 0xFF -> 0x3C.
REQ-042 in_port=0x5A, wait 1 cycle, memread adr=0xFE -> memdata=0x5A; memwrite 0xFE -> no state change.
REQ-043 Reset during RUN -> cpu_reset=1, out_port=0, state LOAD, RAM[0x10] still 0xA5 (readable after reload with 1-byte image).
